// File: rtl/xip_pkg.sv
// Shared types and constants for the XIP AHB front end: FSM encoding,
// AHB transfer/response codes, default geometry and the debug view struct.
package xip_pkg;

  localparam int XIP_ADDR_W    = 24;
  localparam int XIP_LINE_SIZE = 16;
  localparam int XIP_CNT_W     = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOK   = 3'd1,
    ST_FILL   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

  typedef struct packed {
    state_t state;
    logic   wr_r;
    logic   refill;
  } dbg_t;

endpackage

// File: rtl/xip_ahb_ctrl_if.sv
// AHB-Lite slave-side signal bundle. The master modport is the bus matrix
// (or a bench) driving address/control; the slave modport is the XIP front end.
interface xip_ahb_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/xip_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module xip_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/xip_ahb_ctrl.sv
// AHB-Lite read-only slave in front of the XIP line cache and flash line reader.
// Hits finish with zero wait states; misses stall the bus while a line is fetched.
module xip_ahb_ctrl
  import xip_pkg::*;
#(
  parameter int ADDR_W    = XIP_ADDR_W,
  parameter int LINE_SIZE = XIP_LINE_SIZE,
  parameter int CNT_W     = XIP_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  xip_ahb_ctrl_if.slave     bus,
  output logic [ADDR_W-1:0] c_A,
  output logic [ADDR_W-1:0] c_A_h,
  input  logic [31:0]       c_Do,
  input  logic              c_hit,
  output logic              c_wr,
  output logic [ADDR_W-1:0] fr_addr,
  output logic              fr_rd,
  input  logic              fr_done,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output dbg_t              dbg
);

  localparam int OFS_W = $clog2(LINE_SIZE);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_r;
  logic              wr_r;
  logic              refill;

  logic        xfer_valid;
  logic        accept;
  logic        hready_o;
  logic        hresp_o;
  logic [31:0] hrdata_o;
  logic        hit_inc;
  logic        miss_inc;

  // Handshake: an address phase is taken when HSEL & HTRANS[1] & HREADY are high
  // at posedge clk and this slave is in a state that can end a data phase
  // (accept); a data phase ends only in a cycle where HREADYOUT is high.
  assign xfer_valid = bus.HSEL & bus.HTRANS[1] & bus.HREADY;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      addr_r <= '0;
      wr_r   <= 1'b0;
      refill <= 1'b0;
    end else begin
      state  <= state_nx;
      // LOOK entered from COMMIT is the replay of a miss, not a fresh hit.
      refill <= (state == ST_COMMIT);
      if (accept && xfer_valid) begin
        addr_r <= bus.HADDR[ADDR_W-1:0];
        wr_r   <= bus.HWRITE;
      end
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    hready_o = 1'b1;
    hresp_o  = HRESP_OKAY;
    hrdata_o = 32'h0;
    fr_rd    = 1'b0;
    c_wr     = 1'b0;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;

    case (state)
      ST_IDLE: begin
        accept = 1'b1;
      end
      ST_LOOK: begin
        if (c_hit) begin
          hrdata_o = c_Do;
          hit_inc  = ~refill;
          accept   = 1'b1;
        end else begin
          hready_o = 1'b0;
          fr_rd    = 1'b1;
          miss_inc = 1'b1;
          state_nx = ST_FILL;
        end
      end
      ST_FILL: begin
        hready_o = 1'b0;
        if (fr_done) state_nx = ST_COMMIT;
      end
      ST_COMMIT: begin
        hready_o = 1'b0;
        c_wr     = 1'b1;
        state_nx = ST_LOOK;
      end
      ST_ERR1: begin
        hready_o = 1'b0;
        hresp_o  = HRESP_ERROR;
        state_nx = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_o = HRESP_ERROR;
        accept  = 1'b1;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // Any state that completes a data phase also decodes the next address phase.
    if (accept) begin
      if (!xfer_valid)      state_nx = ST_IDLE;
      else if (bus.HWRITE)  state_nx = ST_ERR1;
      else                  state_nx = ST_LOOK;
    end
  end

  assign bus.HREADYOUT = hready_o;
  assign bus.HRESP     = hresp_o;
  assign bus.HRDATA    = hrdata_o;

  assign c_A     = addr_r;
  assign c_A_h   = addr_r;
  assign fr_addr = {addr_r[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

  assign dbg = '{state: state, wr_r: wr_r, refill: refill};

  // Word size is fixed and the upper address bits are outside the flash window.
  logic unused_bits;
  assign unused_bits = ^{bus.HSIZE, bus.HADDR[31:ADDR_W]};

  xip_sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_inc),
    .cnt   (hit_cnt)
  );

  xip_sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_inc),
    .cnt   (miss_cnt)
  );

endmodule

// File: tb/tb_xip_ahb_ctrl.sv
// Bench for xip_ahb_ctrl: cache/reader responders, a transaction-level model,
// and a negedge monitor that scores every data phase against the expected queue.
module tb_xip_ahb_ctrl;
  import xip_pkg::*;

  localparam int ADDR_W    = 24;
  localparam int LINE_SIZE = 16;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  localparam logic [1:0] K_IDLE  = 2'd0;
  localparam logic [1:0] K_READ  = 2'd1;
  localparam logic [1:0] K_WRITE = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic        resp;
    logic [15:0] waits;
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  typedef struct packed {
    logic [23:0] addr;
    logic [7:0]  lat;
  } fill_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xip_ahb_ctrl_if bus ();

  logic [ADDR_W-1:0] c_A, c_A_h, fr_addr;
  logic [31:0]       c_Do;
  logic              c_hit, c_wr, fr_rd, fr_done;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt;
  dbg_t              dbg;

  assign bus.HREADY = bus.HREADYOUT;

  xip_ahb_ctrl #(.ADDR_W(ADDR_W), .LINE_SIZE(LINE_SIZE), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .c_A      (c_A),
    .c_A_h    (c_A_h),
    .c_Do     (c_Do),
    .c_hit    (c_hit),
    .c_wr     (c_wr),
    .fr_addr  (fr_addr),
    .fr_rd    (fr_rd),
    .fr_done  (fr_done),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .dbg      (dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  exp_t  exp_q[$];
  fill_t fill_q[$];
  int    mon_waits = 0;
  logic  done_prev = 1'b0;
  exp_t  mon_e;

  // reference model state: which tag each line index holds, and event counts
  logic [11:0] resident[int];
  int exp_hits   = 0;
  int exp_misses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    logic [31:0] w;
    w = {8'h0, a[23:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // ---------------- cache responder ----------------
  logic         cache_clr = 1'b1;
  logic [255:0] cv;
  logic [11:0]  ctag [256];

  always_comb begin
    c_hit = cv[c_A_h[11:4]] && (ctag[c_A_h[11:4]] == c_A_h[23:12]);
    c_Do  = (cv[c_A[11:4]] && (ctag[c_A[11:4]] == c_A[23:12])) ? flash_word(c_A) : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (cache_clr) begin
      cv <= '0;
    end else if (c_wr) begin
      cv[c_A[11:4]]   <= 1'b1;
      ctag[c_A[11:4]] <= c_A[23:12];
    end
  end

  // ---------------- flash reader responder ----------------
  logic rd_busy = 1'b0;
  int   rd_cnt  = 0;
  initial fr_done = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      rd_busy <= 1'b0;
      fr_done <= 1'b0;
    end else begin
      fr_done <= 1'b0;
      if (rd_busy) begin
        if (rd_cnt == 1) begin
          fr_done <= 1'b1;
          rd_busy <= 1'b0;
        end else begin
          rd_cnt <= rd_cnt - 1;
        end
      end
      if (fr_rd) begin
        rd_busy <= 1'b1;
        if (fill_q.size() > 0) rd_cnt <= int'(fill_q[0].lat) - 1;
        else                   rd_cnt <= 4;
        if (fill_q.size() > 0) void'(fill_q.pop_front());
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev = 1'b0;
    end else begin
      if (fr_rd) begin
        if (fill_q.size() == 0) check("unexpected_fr_rd", {31'b0, fr_rd}, 32'd0);
        else check("fr_addr", {8'h0, fr_addr}, {8'h0, fill_q[0].addr});
      end
      if (c_wr || done_prev) check("c_wr_after_fr_done", {31'b0, c_wr}, {31'b0, done_prev});
      done_prev = fr_done;

      if (exp_q.size() > 0) begin
        mon_e = exp_q[0];
        if (!bus.HREADYOUT) begin
          mon_waits++;
          if (mon_e.kind == K_WRITE)
            check($sformatf("err1_hresp@%h", mon_e.addr), {31'b0, bus.HRESP}, 32'd1);
          if (mon_waits > 400) begin
            check($sformatf("data_phase_timeout@%h", mon_e.addr), mon_waits, {16'h0, mon_e.waits});
            void'(exp_q.pop_front());
            mon_waits = 0;
          end
        end else begin
          check($sformatf("wait_states@%h", mon_e.addr), mon_waits, {16'h0, mon_e.waits});
          check($sformatf("hresp@%h", mon_e.addr), {31'b0, bus.HRESP}, {31'b0, mon_e.resp});
          if (mon_e.kind == K_READ)
            check($sformatf("hrdata@%h", mon_e.addr), bus.HRDATA, mon_e.data);
          void'(exp_q.pop_front());
          mon_waits = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic model_push(input logic [31:0] a, input logic w, input logic sel,
                            input logic [1:0] tr, input int lat);
    exp_t e;
    int   idx;
    e = '0;
    e.addr = a;
    if (!(sel && tr[1])) begin
      e.kind = K_IDLE;
    end else if (w) begin
      e.kind  = K_WRITE;
      e.resp  = 1'b1;
      e.waits = 16'd1;
    end else begin
      idx    = int'(a[11:4]);
      e.kind = K_READ;
      e.data = flash_word(a[23:0]);
      if (resident.exists(idx) && resident[idx] == a[23:12]) begin
        exp_hits++;
      end else begin
        exp_misses++;
        e.waits       = 16'(lat + 2);
        resident[idx] = a[23:12];
        fill_q.push_back('{addr: a[23:0] & ~24'hF, lat: 8'(lat)});
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic sel,
                       input logic [1:0] tr, input int lat);
    int guard = 0;
    while (!bus.HREADYOUT && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 500) check("issue_ready_timeout", guard, 32'd0);
    bus.HSEL   = sel;
    bus.HADDR  = a;
    bus.HTRANS = tr;
    bus.HWRITE = w;
    bus.HSIZE  = 3'($urandom_range(0, 2));
    @(posedge clk); #1;
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HWRITE = 1'b0;
    model_push(a, w, sel, tr, lat);
  endtask

  task automatic rd(input logic [31:0] a, input int lat);
    issue(a, 1'b0, 1'b1, HTRANS_NONSEQ, lat);
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() > 0 && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 2000) begin
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_hit_cnt"},  {28'h0, hit_cnt},  sat(exp_hits));
    check({tag, "_miss_cnt"}, {28'h0, miss_cnt}, sat(exp_misses));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    logic        seen_c_wr;
    logic        had_line;
    logic [11:0] old_tag;
    int          r;

    bus.HSEL   = 1'b0;
    bus.HADDR  = '0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'd2;

    repeat (3) @(posedge clk);
    #1;
    check("rst_hreadyout", {31'b0, bus.HREADYOUT}, 32'd1);
    check("rst_hresp",     {31'b0, bus.HRESP},     32'd0);
    check("rst_hrdata",    bus.HRDATA,             32'd0);
    check("rst_fr_rd",     {31'b0, fr_rd},         32'd0);
    check("rst_c_wr",      {31'b0, c_wr},          32'd0);
    check("rst_c_A",       {8'h0, c_A},            32'd0);
    check("rst_state",     {29'b0, dbg.state},     {29'b0, ST_IDLE});
    check_counters("rst");
    rst_n     = 1'b1;
    cache_clr = 1'b0;
    @(posedge clk); #1;

    // cold miss then same-line hits
    rd(32'h0000_0104, 20);
    drain();
    check_counters("cold");
    rd(32'h0000_0100, 20);
    rd(32'h0000_0108, 20);
    rd(32'h0000_010C, 20);
    drain();
    check_counters("hits");

    // write is rejected; no-transfer cycles stay zero-wait OKAY
    issue(32'h0000_0010, 1'b1, 1'b1, HTRANS_NONSEQ, 20);
    issue(32'h0000_0104, 1'b0, 1'b0, HTRANS_NONSEQ, 20);
    issue(32'h0000_0104, 1'b0, 1'b1, HTRANS_BUSY, 20);
    drain();
    check_counters("write");

    // same index, new tag, then the evicted line again
    rd(32'h0000_1104, 12);
    rd(32'h0000_0104, 7);
    rd(32'h0000_0108, 7);
    drain();
    check_counters("conflict");

    // random mix over a small line pool so hits, conflicts and errors interleave
    for (int i = 0; i < 150; i++) begin
      a = {8'($urandom), 12'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 4'($urandom)};
      r = $urandom_range(0, 9);
      if (r == 0)      issue(a, 1'b1, 1'b1, HTRANS_SEQ, 5);
      else if (r == 1) issue(a, 1'b0, 1'($urandom_range(0, 1)), HTRANS_BUSY, 5);
      else             issue(a, 1'b0, 1'b1, 2'($urandom_range(2, 3)), $urandom_range(3, 25));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    drain();
    check_counters("random");

    // hit counter saturation
    rd(32'h0000_0204, 6);
    for (int i = 0; i < CNT_MAX + 4; i++) rd(32'h0000_0200 + 32'(4 * (i % 4)), 6);
    drain();
    check_counters("saturate");
    check("hit_cnt_saturated", {28'h0, hit_cnt}, CNT_MAX);

    // reset while a fill is outstanding
    had_line = resident.exists(3);
    old_tag  = had_line ? resident[3] : 12'h0;
    rd(32'h0000_7034, 60);
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_in_fill", {29'b0, dbg.state}, {29'b0, ST_FILL});
    rst_n = 1'b0;
    exp_q.delete();
    fill_q.delete();
    mon_waits  = 0;
    exp_hits   = 0;
    exp_misses = 0;
    if (had_line) resident[3] = old_tag;
    else          resident.delete(3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midfill_rst_hreadyout", {31'b0, bus.HREADYOUT}, 32'd1);
    check("midfill_rst_state",     {29'b0, dbg.state},     {29'b0, ST_IDLE});
    check_counters("midfill_rst");
    seen_c_wr = 1'b0;
    repeat (70) begin
      @(negedge clk);
      seen_c_wr = seen_c_wr | c_wr;
    end
    @(posedge clk); #1;
    check("midfill_no_c_wr", {31'b0, seen_c_wr}, 32'd0);

    // the aborted line is fetched again from scratch
    rd(32'h0000_7034, 5);
    rd(32'h0000_7038, 5);
    drain();
    check_counters("post_rst");

    check("exp_q_empty",  exp_q.size(),  32'd0);
    check("fill_q_empty", fill_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
